// File: rtl/tx_lane_scheduler.sv
// tx_lane_scheduler: two-requester round-robin byte scheduler for one transmit lane.
//   Params : TRAIN_LEN    - COM cycles emitted after reset release before arbitration
//            SKP_INTERVAL - ARB slots between SKP ordered sets (8..255)
//   Macro  : SKP_INSERT_EN - when defined, periodic SKP ordered sets are inserted
//   Inputs : clk_4f, reset (async, active-low), reqN_data/valid/last
//   Outputs: reqN_ready (combinational), data_out/valid_out (registered),
//            grant (one-hot packet owner), skp_active
module tx_lane_scheduler #(
  parameter int TRAIN_LEN    = 8,
  parameter int SKP_INTERVAL = 32
) (
  input  logic       clk_4f,
  input  logic       reset,
  input  logic [7:0] req0_data,
  input  logic       req0_valid,
  input  logic       req0_last,
  output logic       req0_ready,
  input  logic [7:0] req1_data,
  input  logic       req1_valid,
  input  logic       req1_last,
  output logic       req1_ready,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic [1:0] grant,
  output logic       skp_active
);
  localparam int TW = (TRAIN_LEN > 1) ? $clog2(TRAIN_LEN) : 1;
  localparam logic [7:0] COM = 8'hBC;

  if (TRAIN_LEN < 1) begin : g_bad_train
    $error("TRAIN_LEN must be at least 1");
  end
  if (SKP_INTERVAL < 8 || SKP_INTERVAL > 255) begin : g_bad_skp
    $error("SKP_INTERVAL must be in 8..255");
  end

`ifdef SKP_INSERT_EN
  localparam logic [7:0] SKP_SYM = 8'h1C;
  typedef enum logic [1:0] {TRAIN, ARB, SKP} state_e;
`else
  typedef enum logic [1:0] {TRAIN, ARB} state_e;
`endif

  state_e        state_q, state_d;
  logic [TW-1:0] train_q, train_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic [1:0]    grant_q, grant_d;
  logic          ptr_q, ptr_d;
  logic          lock, win1, stall, hs0, hs1, acc_last;

`ifdef SKP_INSERT_EN
  logic [7:0] slot_q, slot_d;
  logic [1:0] seq_q, seq_d;
  logic       pend_q, pend_d, skp_q, skp_d, wrap, pend;
  // A wrap in the current slot counts as pending at once, so an idle lane
  // starts the SKP exactly SKP_INTERVAL slots after the previous one.
  assign wrap  = state_q == ARB && slot_q == 8'(SKP_INTERVAL - 1);
  assign pend  = pend_q || wrap;
  assign stall = pend && !lock;
`else
  assign stall = 1'b0;
`endif

  // win1: requester 1 owns this cycle (lock owner, else round-robin among valid)
  assign lock       = |grant_q;
  assign win1       = lock ? grant_q[1] : req1_valid && (!req0_valid || ptr_q);
  assign req0_ready = state_q == ARB && !stall && !win1 && (lock || req0_valid);
  assign req1_ready = state_q == ARB && !stall && win1;
  assign hs0        = req0_ready && req0_valid;
  assign hs1        = req1_ready && req1_valid;
  assign acc_last   = hs1 ? req1_last : hs0 && req0_last;

  always_comb begin
    state_d = state_q;
    train_d = train_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    data_d  = hs1 ? req1_data : hs0 ? req0_data : COM;
    valid_d = hs0 || hs1;
`ifdef SKP_INSERT_EN
    slot_d  = slot_q;
    seq_d   = seq_q;
    pend_d  = pend_q;
    skp_d   = 1'b0;
`endif
    if (state_q == TRAIN) begin
      train_d = train_q + 1'b1;
      if (train_q == TW'(TRAIN_LEN - 1)) state_d = ARB;
    end
    if (hs0 || hs1) begin
      grant_d = acc_last ? 2'b00 : {hs1, hs0};
      ptr_d   = acc_last ? hs0 : ptr_q;
    end
`ifdef SKP_INSERT_EN
    if (state_q == ARB) begin
      slot_d = wrap ? 8'd0 : slot_q + 8'd1;
      pend_d = pend;
      seq_d  = 2'd0;
      if (pend && (!lock || acc_last)) state_d = SKP;
    end
    if (state_q == SKP) begin
      data_d  = seq_q == 2'd0 ? COM : SKP_SYM;
      valid_d = 1'b1;
      skp_d   = 1'b1;
      seq_d   = seq_q + 2'd1;
      if (seq_q == 2'd3) begin
        state_d = ARB;
        slot_d  = 8'd0;
        pend_d  = 1'b0;
      end
    end
`endif
  end

  always_ff @(posedge clk_4f or negedge reset) begin
    if (!reset) begin
      state_q <= TRAIN;
      train_q <= '0;
      data_q  <= COM;
      valid_q <= 1'b0;
      grant_q <= 2'b00;
      ptr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      train_q <= train_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

`ifdef SKP_INSERT_EN
  always_ff @(posedge clk_4f or negedge reset) begin
    if (!reset) begin
      slot_q <= 8'd0;
      seq_q  <= 2'd0;
      pend_q <= 1'b0;
      skp_q  <= 1'b0;
    end else begin
      slot_q <= slot_d;
      seq_q  <= seq_d;
      pend_q <= pend_d;
      skp_q  <= skp_d;
    end
  end
  assign skp_active = skp_q;
`else
  assign skp_active = 1'b0;
`endif

  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign grant     = grant_q;
endmodule

// File: tb/tb_tx_lane_scheduler.sv
// tb_tx_lane_scheduler: directed self-checking bench for tx_lane_scheduler
module tb_tx_lane_scheduler;
  logic       clk_4f = 1'b0;
  logic       reset;
  logic [7:0] req0_data, req1_data, data_out;
  logic       req0_valid, req0_last, req0_ready;
  logic       req1_valid, req1_last, req1_ready;
  logic       valid_out, skp_active;
  logic [1:0] grant;
  int         checks = 0;
  int         errors = 0;
`ifdef SKP_INSERT_EN
  int         i, ph;
  logic       h;
`else
  int         i0, i1;
  logic       h0, h1;
  logic [7:0] exp_d [9] = '{8'h01, 8'h02, 8'h03, 8'h11, 8'h12, 8'h13, 8'h01, 8'h02, 8'h03};
  logic [1:0] exp_g [9] = '{2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00, 2'b01, 2'b01, 2'b00};
`endif

  always #5 clk_4f = ~clk_4f;

  tx_lane_scheduler #(.TRAIN_LEN(8), .SKP_INTERVAL(8)) dut (
    .clk_4f(clk_4f), .reset(reset),
    .req0_data(req0_data), .req0_valid(req0_valid), .req0_last(req0_last), .req0_ready(req0_ready),
    .req1_data(req1_data), .req1_valid(req1_valid), .req1_last(req1_last), .req1_ready(req1_ready),
    .data_out(data_out), .valid_out(valid_out), .grant(grant), .skp_active(skp_active)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_4f);
    #2;
  endtask

  task automatic out_chk(input string tag, input logic [7:0] d, input logic v, input logic s,
                         input logic [1:0] g);
    chk(tag, {skp_active, grant, valid_out, data_out}, {s, g, v, d});
  endtask

  task automatic rst_chk(input string tag);
    chk(tag, {req0_ready, req1_ready, skp_active, grant, valid_out, data_out}, 16'h00BC);
  endtask

  task automatic train_chk(input string tag);
    for (int k = 0; k < 8; k++) begin
      rst_chk(tag);
      tick;
    end
  endtask

  initial begin
    reset = 1'b0;
    req0_data = 8'h5A; req0_valid = 1'b1; req0_last = 1'b1;
    req1_data = 8'h00; req1_valid = 1'b0; req1_last = 1'b0;
    tick;
    tick;
    rst_chk("reset");
    reset = 1'b1;
    train_chk("train");
    #1 chk("ready0_first", {req0_ready, req1_ready}, 2'b10);
    tick;
    out_chk("byte_5a", 8'h5A, 1'b1, 1'b0, 2'b00);
    req0_valid = 1'b0;
`ifdef SKP_INSERT_EN
    for (int e = 10; e <= 32; e++) begin
      tick;
      ph = (e + 7) % 12;
      out_chk("skp_idle", ph == 0 ? 8'hBC : ph < 4 ? 8'h1C : 8'hBC, ph < 4, ph < 4, 2'b00);
    end
    i = 0;
    for (int e = 33; e <= 44; e++) begin
      req1_valid = i < 10;
      req1_data  = 8'hD0 + 8'(i);
      req1_last  = i == 9;
      #1 h = req1_ready && req1_valid;
      tick;
      if (h) i++;
      if (e <= 42) out_chk("pkt_wrap", 8'hD0 + 8'(e - 33), 1'b1, 1'b0, e == 42 ? 2'b00 : 2'b10);
      else out_chk("skp_after", e == 43 ? 8'hBC : 8'h1C, 1'b1, 1'b1, 2'b00);
    end
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_data = 8'h5A; req0_last = 1'b1;
    reset = 1'b0;
    #1 rst_chk("reset_mid_skp");
    tick;
    rst_chk("reset_hold");
    reset = 1'b1;
    train_chk("retrain");
    #1 chk("ready0_retrain", {req0_ready, req1_ready}, 2'b10);
`else
    req0_valid = 1'b1; req0_data = 8'h77; req0_last = 1'b0;
    req1_valid = 1'b1; req1_data = 8'hA1; req1_last = 1'b0;
    #1 chk("rr_ptr_req1", {req0_ready, req1_ready}, 2'b01);
    tick;
    out_chk("lock_a1", 8'hA1, 1'b1, 1'b0, 2'b10);
    req1_valid = 1'b0;
    #1 chk("lock_block", {req0_ready, req1_ready}, 2'b01);
    tick;
    out_chk("idle1", 8'hBC, 1'b0, 1'b0, 2'b10);
    tick;
    out_chk("idle2", 8'hBC, 1'b0, 1'b0, 2'b10);
    req1_valid = 1'b1; req1_data = 8'hA2; req1_last = 1'b1;
    tick;
    out_chk("last_a2", 8'hA2, 1'b1, 1'b0, 2'b00);
    req1_valid = 1'b0;
    #1 chk("ptr_req0", {req0_ready, req1_ready}, 2'b10);
    tick;
    out_chk("lock_77", 8'h77, 1'b1, 1'b0, 2'b01);
    req0_data = 8'h78;
    reset = 1'b0;
    #1 rst_chk("reset_mid_pkt");
    tick;
    rst_chk("reset_hold");
    reset = 1'b1;
    train_chk("retrain");
    req1_valid = 1'b1;
    i0 = 0;
    i1 = 0;
    for (int k = 0; k < 9; k++) begin
      req0_data = 8'h01 + 8'(i0); req0_last = i0 == 2;
      req1_data = 8'h11 + 8'(i1); req1_last = i1 == 2;
      #1;
      if (k == 0) chk("rr_first", {req0_ready, req1_ready}, 2'b10);
      h0 = req0_ready && req0_valid;
      h1 = req1_ready && req1_valid;
      tick;
      if (h0) i0 = i0 == 2 ? 0 : i0 + 1;
      if (h1) i1 = i1 == 2 ? 0 : i1 + 1;
      out_chk("stream", exp_d[k], 1'b1, 1'b0, exp_g[k]);
    end
    req1_valid = 1'b0;
    for (int j = 0; j < 100; j++) begin
      req0_data = 8'h40 + 8'(j % 64);
      req0_last = j % 4 == 3;
      tick;
      chk("no_skp", {skp_active, valid_out, data_out}, {1'b0, 1'b1, 8'h40 + 8'(j % 64)});
    end
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
